// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit path.
package vend_pkg;

  localparam int CENTS_W = 10;

  typedef logic [CENTS_W-1:0] cents_t;
  typedef logic [1:0]         item_t;

  localparam cents_t COIN_NICKEL  = 10'd5;
  localparam cents_t COIN_DIME    = 10'd10;
  localparam cents_t COIN_QUARTER = 10'd25;
  localparam cents_t COIN_DOLLAR  = 10'd100;

  typedef enum logic {
    COLLECT = 1'b0,
    WAIT    = 1'b1
  } state_t;

  // Registered output bundle of the controller.
  typedef struct packed {
    cents_t credit;
    cents_t change;
    logic   vend;
    item_t  vend_item;
    logic   coin_reject;
    logic   insufficient;
    logic   busy;
  } vend_out_t;

endpackage

// File: rtl/vend_wait_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module vend_wait_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count;

  // Load has priority over decrement; the count never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst)                       count <= '0;
    else if (load)                 count <= load_val;
    else if (dec && count != '0)   count <= count - 1'b1;
  end

  assign done = (count == '0);

endmodule

// File: rtl/vend_credit_controller.sv
// Coin credit accumulator and sale decision for the vending machine.
// Optional refund path enabled by defining VEND_REFUND_EN.
module vend_credit_controller #(
  parameter int PRICE0        = 65,
  parameter int PRICE1        = 100,
  parameter int PRICE2        = 50,
  parameter int PRICE3        = 125,
  parameter int MAX_CREDIT    = 1000,
  parameter int DISPENSE_WAIT = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_nickel,
  input  logic       coin_dime,
  input  logic       coin_quarter,
  input  logic       coin_dollar,
  input  logic       sel_valid,
  input  logic [1:0] sel,
`ifdef VEND_REFUND_EN
  input  logic       refund,
`endif
  output logic [9:0] credit,
  output logic [9:0] change,
  output logic       vend,
  output logic [1:0] vend_item,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       busy
);
  import vend_pkg::*;

  localparam int TW = (DISPENSE_WAIT > 2) ? $clog2(DISPENSE_WAIT) : 1;
  localparam logic [TW-1:0]      WAIT_LOAD = TW'(DISPENSE_WAIT - 1);
  localparam logic [CENTS_W:0]   MAX_C     = (CENTS_W+1)'(MAX_CREDIT);

  state_t             state, state_nxt;
  vend_out_t          out_q, out_nxt;
  cents_t             price, coin_val;
  logic [CENTS_W:0]   coin_sum;
  logic               coin_any, coin_multi;
  logic               settle;
  logic               tmr_load, tmr_dec, tmr_done;

  // Price lookup for the requested item.
  always_comb begin
    case (sel)
      2'd0:    price = CENTS_W'(PRICE0);
      2'd1:    price = CENTS_W'(PRICE1);
      2'd2:    price = CENTS_W'(PRICE2);
      default: price = CENTS_W'(PRICE3);
    endcase
  end

  // Highest-value coin wins when several are offered together.
  always_comb begin
    coin_val = '0;
    if (coin_dollar)       coin_val = COIN_DOLLAR;
    else if (coin_quarter) coin_val = COIN_QUARTER;
    else if (coin_dime)    coin_val = COIN_DIME;
    else if (coin_nickel)  coin_val = COIN_NICKEL;
  end

  assign coin_any   = coin_nickel | coin_dime | coin_quarter | coin_dollar;
  assign coin_multi = $countones({coin_nickel, coin_dime, coin_quarter, coin_dollar}) > 1;
  assign coin_sum   = {1'b0, out_q.credit} + {1'b0, coin_val};

  // Next-state and next-output decision; selection uses the pre-coin credit.
  always_comb begin
    state_nxt            = state;
    out_nxt              = out_q;
    out_nxt.change       = '0;
    out_nxt.vend         = 1'b0;
    out_nxt.coin_reject  = 1'b0;
    out_nxt.insufficient = 1'b0;
    settle               = 1'b0;
    tmr_load             = 1'b0;
    tmr_dec              = 1'b0;
    case (state)
      COLLECT: begin
        if (sel_valid) begin
          if (out_q.credit >= price) begin
            settle            = 1'b1;
            out_nxt.vend      = 1'b1;
            out_nxt.vend_item = sel;
            out_nxt.change    = out_q.credit - price;
            out_nxt.credit    = '0;
            // A zero-change sale never engages the dispenser, so no hold-off.
            if (out_q.credit != price) begin
              state_nxt = WAIT;
              tmr_load  = 1'b1;
            end
          end else begin
            out_nxt.insufficient = 1'b1;
          end
        end
`ifdef VEND_REFUND_EN
        else if (refund && out_q.credit != '0) begin
          settle         = 1'b1;
          out_nxt.change = out_q.credit;
          out_nxt.credit = '0;
          state_nxt      = WAIT;
          tmr_load       = 1'b1;
        end
`endif
        // Credit is being paid out this cycle, so a coin cannot be banked.
        if (coin_any) begin
          if (settle || coin_multi || coin_sum > MAX_C) out_nxt.coin_reject = 1'b1;
          if (!settle && coin_sum <= MAX_C)             out_nxt.credit = coin_sum[CENTS_W-1:0];
        end
      end
      WAIT: begin
        out_nxt.coin_reject = coin_any;
        if (tmr_done) state_nxt = COLLECT;
        else          tmr_dec   = 1'b1;
      end
      default: state_nxt = COLLECT;
    endcase
    out_nxt.busy = (state_nxt == WAIT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= COLLECT;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      out_q <= out_nxt;
    end
  end

  vend_wait_timer #(.W(TW)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (WAIT_LOAD),
    .dec      (tmr_dec),
    .done     (tmr_done)
  );

  assign credit       = out_q.credit;
  assign change       = out_q.change;
  assign vend         = out_q.vend;
  assign vend_item    = out_q.vend_item;
  assign coin_reject  = out_q.coin_reject;
  assign insufficient = out_q.insufficient;
  assign busy         = out_q.busy;

endmodule
